// File: rtl/wb_trace_logger.sv
// wb_trace_logger: FIFO of committed GRF/DM write records drained over valid/ready,
// with drop accounting when the buffer cannot take every event.
module wb_trace_logger #(
    parameter int DEPTH       = 16,
    parameter int PTR_W       = 4,
    parameter bit FILTER_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_data,
    input  logic             dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_kind,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    output logic [PTR_W:0]   level
);
    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W + 2)'(DEPTH);

    rec_t             mem [DEPTH];
    rec_t             grf_rec, dm_rec, head;
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W+1:0] space;
    logic             g, d, pop, acc_g, acc_d;
    logic [1:0]       n_acc, n_drop;
    logic [16:0]      drop_sum;

    assign out_valid = level != '0;
    assign grf_rec   = '{kind: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_data};
    assign dm_rec    = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_data};
    assign out_kind  = head.kind;
    assign out_pc    = head.pc;
    assign out_addr  = head.addr;
    assign out_data  = head.data;

    // A pop frees its slot this cycle; GRF claims space before DM.
    always_comb begin
        g        = grf_we & ~(FILTER_ZERO & (grf_addr == 5'd0));
        d        = dm_we;
        pop      = out_valid & out_ready;
        space    = DEPTH_W - {1'b0, level} + {{(PTR_W + 1){1'b0}}, pop};
        acc_g    = g & (space != '0);
        acc_d    = d & (space > {{(PTR_W + 1){1'b0}}, acc_g});
        n_acc    = {1'b0, acc_g} + {1'b0, acc_d};
        n_drop   = {1'b0, g & ~acc_g} + {1'b0, d & ~acc_d};
        drop_sum = {1'b0, drop_cnt} + {15'd0, n_drop};
        head     = out_valid ? mem[rptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (acc_g) mem[wptr] <= grf_rec;
            if (acc_d) mem[wptr + {{(PTR_W - 1){1'b0}}, acc_g}] <= dm_rec;
            wptr     <= wptr + PTR_W'(n_acc);
            rptr     <= rptr + {{(PTR_W - 1){1'b0}}, pop};
            level    <= level + (PTR_W + 1)'(n_acc) - {{PTR_W{1'b0}}, pop};
            overflow <= overflow | (n_drop != 2'd0);
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule

// File: tb/tb_wb_trace_logger.sv
// tb_wb_trace_logger: vector table, hand-written overflow/reset sequences and a
// randomized run against a queue-based model of the trace FIFO.
module tb_wb_trace_logger;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        grf_we, dm_we, out_ready;
    logic [31:0] grf_pc, grf_data, dm_pc, dm_addr, dm_data;
    logic [4:0]  grf_addr;
    logic        out_valid, out_kind, overflow;
    logic [31:0] out_pc, out_addr, out_data;
    logic [15:0] drop_cnt;
    logic [4:0]  level;

    int checks = 0;
    int failures = 0;

    wb_trace_logger #(.DEPTH(16), .PTR_W(4), .FILTER_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        logic gwe; logic [31:0] gpc; logic [4:0] ga; logic [31:0] gd;
        logic dwe; logic [31:0] dpc; logic [31:0] da; logic [31:0] dd;
        logic rdy;
        int lvl; logic vld; logic kind; logic [31:0] pc; logic [31:0] addr; logic [31:0] data; int drop;
    } vec_t;

    rec_t q[$];
    int   m_drop;
    bit   m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        grf_we = 0; grf_pc = 0; grf_addr = 0; grf_data = 0;
        dm_we = 0; dm_pc = 0; dm_addr = 0; dm_data = 0;
    endtask

    // Model: pop first (frees a slot), then GRF then DM take whatever room remains.
    task automatic model_edge();
        int dropped = 0;
        if (reset) begin
            q.delete(); m_drop = 0; m_ovf = 0;
            return;
        end
        if (out_ready && q.size() > 0) q.delete(0);
        if (grf_we && grf_addr != 0) begin
            if (q.size() < DEPTH) q.push_back({1'b0, grf_pc, {27'd0, grf_addr}, grf_data});
            else dropped++;
        end
        if (dm_we) begin
            if (q.size() < DEPTH) q.push_back({1'b1, dm_pc, dm_addr, dm_data});
            else dropped++;
        end
        m_drop = (m_drop + dropped > 65535) ? 65535 : m_drop + dropped;
        if (dropped > 0) m_ovf = 1;
    endtask

    task automatic cmp_model();
        rec_t h = (q.size() > 0) ? q[0] : '0;
        chk("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("rnd_level", 32'(level), 32'(q.size()));
        chk("rnd_kind", 32'(out_kind), 32'(h.kind));
        chk("rnd_pc", out_pc, h.pc);
        chk("rnd_addr", out_addr, h.addr);
        chk("rnd_data", out_data, h.data);
        chk("rnd_drop", 32'(drop_cnt), 32'(m_drop));
        chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        vec_t tbl[8];
        int rdy_bias;
        tbl[0] = '{1, 32'h3000, 5'd8, 32'h12345678, 0, 0, 0, 0, 1, 1, 1, 0, 32'h3000, 32'd8, 32'h12345678, 0};
        tbl[1] = '{0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 32'h3004, 5'd9, 32'hAA, 1, 32'h3004, 32'h10, 32'hBB, 1, 2, 1, 0, 32'h3004, 32'd9, 32'hAA, 0};
        tbl[3] = '{0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h3004, 32'h10, 32'hBB, 0};
        tbl[4] = '{0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 32'h3008, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 32'h300C, 5'd0, 32'h1, 1, 32'h300C, 32'h20, 32'h55, 0, 1, 1, 1, 32'h300C, 32'h20, 32'h55, 0};
        tbl[7] = '{0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

        reset = 1; out_ready = 0; idle_inputs();
        #1; step(); step();
        reset = 0;
        repeat (5) step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_pc", out_pc, 0);

        foreach (tbl[i]) begin
            grf_we = tbl[i].gwe; grf_pc = tbl[i].gpc; grf_addr = tbl[i].ga; grf_data = tbl[i].gd;
            dm_we = tbl[i].dwe; dm_pc = tbl[i].dpc; dm_addr = tbl[i].da; dm_data = tbl[i].dd;
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_kind", i), 32'(out_kind), 32'(tbl[i].kind));
            chk($sformatf("v%0d_pc", i), out_pc, tbl[i].pc);
            chk($sformatf("v%0d_addr", i), out_addr, tbl[i].addr);
            chk($sformatf("v%0d_data", i), out_data, tbl[i].data);
            chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
        end
        idle_inputs();

        // Overflow: 18 GRF pushes into 16 slots with the sink stalled.
        out_ready = 0;
        for (int i = 0; i < 18; i++) begin
            grf_we = 1; grf_pc = 32'h4000 + 32'(i * 4); grf_addr = 5'(i % 31 + 1); grf_data = 32'(i);
            step();
            if (i == 15) chk("ovf_not_yet", 32'(overflow), 0);
        end
        chk("full_level", 32'(level), 16);
        chk("full_drop", 32'(drop_cnt), 2);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_head", out_data, 0);
        grf_we = 1; grf_addr = 5'd5; grf_data = 32'h100; grf_pc = 32'h5000;
        dm_we = 1; dm_addr = 32'h40; dm_data = 32'h200; dm_pc = 32'h5000;
        out_ready = 1;
        step();
        idle_inputs();
        chk("popfull_level", 32'(level), 16);
        chk("popfull_drop", 32'(drop_cnt), 3);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d_data", i), out_data, (i == 16) ? 32'h100 : 32'(i));
            chk($sformatf("drain%0d_kind", i), 32'(out_kind), 0);
            step();
        end
        chk("drained_level", 32'(level), 0);
        chk("drained_ovf", 32'(overflow), 1);

        // Mid-operation reset discards contents and the event presented alongside it.
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            grf_we = 1; grf_addr = 5'd3; grf_data = 32'(i + 50);
            step();
        end
        chk("pre_rst_level", 32'(level), 5);
        reset = 1; grf_data = 32'hDEAD;
        step();
        reset = 0; idle_inputs();
        chk("midrst_level", 32'(level), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_drop", 32'(drop_cnt), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        step();
        chk("midrst_after", 32'(level), 0);

        // Randomized run against the model.
        reset = 1; model_edge(); step(); reset = 0;
        rdy_bias = 2;
        for (int c = 0; c < 3000; c++) begin
            cmp_model();
            if (c % 200 == 0) rdy_bias = $urandom_range(0, 4);
            reset     = ($urandom_range(0, 399) == 0);
            out_ready = ($urandom_range(0, 3) < rdy_bias);
            grf_we    = $urandom_range(0, 1);
            grf_pc    = $urandom;
            grf_addr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            grf_data  = $urandom;
            dm_we     = ($urandom_range(0, 2) == 0);
            dm_pc     = $urandom;
            dm_addr   = $urandom;
            dm_data   = $urandom;
            model_edge();
            step();
        end
        cmp_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_trace_logger.md
Name: wb_trace_logger

Overview:
- Captures the architectural write events the mips core commits each cycle: GRF writes and DM writes.
- Buffers them as ordered records in a FIFO and drains them one record per valid/ready handshake to a trace sink.
- The trace sink is a file writer in simulation or a UART/debug port on board.
- The block is the receiving end of the core's commit stream. The auto-test compares its record sequence against the golden simulator trace.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- PTR_W, 4, log2(DEPTH).
- FILTER_ZERO, 1, when 1, GRF writes to register 0 are discarded and never recorded.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- grf_we  input  1  GRF write committed this cycle.
- grf_pc  input  32  PC of the instruction doing the GRF write.
- grf_addr  input  5  destination register.
- grf_data  input  32  value written.
- dm_we  input  1  DM write committed this cycle.
- dm_pc  input  32  PC of the store instruction.
- dm_addr  input  32  byte address.
- dm_data  input  32  value written.
- out_valid  output  1  head record available.
- out_ready  input  1  sink accepts the head record.
- out_kind  output  1  0 = GRF record, 1 = DM record.
- out_pc  output  32  head record PC.
- out_addr  output  32  head record address; GRF records are zero-extended from 5 bits.
- out_data  output  32  head record data.
- overflow  output  1  sticky; set when any event was dropped.
- drop_cnt  output  16  number of dropped events, saturating at 16'hFFFF.
- level  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset, synchronous and active-high:
  - Read and write pointers cleared, level = 0, out_valid = 0.
  - overflow = 0, drop_cnt = 0.
  - Output record fields read as 0 while the FIFO is empty.
  - Reset asserted mid-operation discards all buffered records on that edge. Events presented in the reset cycle are not recorded.
- Event qualification:
  - g = grf_we & ~(FILTER_ZERO & grf_addr == 0).
  - d = dm_we.
  - Pushes this cycle: n_push = g + d, range 0..2.
- Ordering: when g and d are both set in the same cycle, the GRF record is written first (lower FIFO slot) and the DM record second.
- Pop: occurs when out_valid & out_ready. A pop frees its slot in the same cycle, so space = DEPTH - level + pop.
- Capacity and overflow:
  - If n_push <= space, all events are accepted.
  - If n_push = 2 and space = 1, GRF is accepted and DM is dropped.
  - If space = 0, all qualifying events are dropped.
  - Each dropped event increments drop_cnt by 1 (by 2 if both are dropped), saturating.
  - overflow is set on the edge after the first drop and cleared only by reset.
- Level update: level_next = level + accepted - pop.
- Output timing:
  - out_valid = (level != 0).
  - out_* show the head slot directly from storage (first-word fall-through).
  - Zero latency from storage to output. A record pushed at edge N is visible at out_* after edge N when the FIFO was empty.
- Stability: while out_valid & ~out_ready, the out_* fields must hold stable.
- Pointer arithmetic: pointers are PTR_W bits and wrap modulo DEPTH. Full and empty are derived from level, not from pointer equality.
- Simultaneous events: pop at full together with one push gives level unchanged, no drop. Pop at full with two pushes accepts GRF and drops DM.

Test Plan:
- Reset, then idle 5 cycles -> out_valid=0, level=0, overflow=0, drop_cnt=0, out_pc=0.
- grf_we=1, pc=0x00003000, addr=8, data=0x12345678, out_ready=1 -> next cycle out_valid=1, kind=0, addr=8, data=0x12345678. Popped that cycle, level returns to 0.
- Same cycle: GRF (pc 0x3004, $9, 0xAA) and DM (pc 0x3004, addr 0x10, 0xBB), out_ready=1 -> two consecutive handshakes: kind 0 then kind 1, addr 0x10, data 0xBB.
- grf_we=1 with addr=0, data=0xFFFFFFFF, FILTER_ZERO=1 -> level stays 0, no drop counted.
- out_ready=0, push 18 single GRF events (DEPTH=16) -> level=16, drop_cnt=2, overflow=1. At full, GRF+DM plus a pop -> GRF accepted, DM dropped, drop_cnt=3. Draining gives records in original push order.
- Fill 5 records, assert reset for 1 cycle with grf_we=1 -> level=0, out_valid=0, drop_cnt=0. The reset-cycle event is not recorded.
